ula_nbits_seq: RTL and testbench

ULA_NBITS_SEQ -- requirements
Module: ula_nbits_seq

---
 rtl/ula_nbits_seq.sv | 186 ++++++++++++++++++
 tb/tb_ula_nbits_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_nbits_seq.sv
// Sequential N-bit ALU: single-cycle add/sub/logic, W-step shift-add multiply and
// restoring divide, registered results with saturation and {E,V,N,C,Z} flags.
module ula_nbits_seq #(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ula_start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   Sel,
  output logic [W-1:0] S,
  output logic [W-1:0] SS,
  output logic [W-1:0] res_div_res,
  output logic [4:0]   flags,
  output logic         busy,
  output logic         ula_pronto
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int            CW       = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);
  localparam logic [2:0]    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                            OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_NOT = 3'd7;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [2:0]      sel_q, sel_d;
  logic [2*W-1:0]  prod_q, prod_d, mcand_q, mcand_d;
  logic [W-1:0]    rem_q, rem_d, quo_q, quo_d;
  logic [W-1:0]    s_q, s_d, ss_q, ss_d, rdr_q, rdr_d;
  logic [4:0]      flags_q, flags_d;

  logic            load;
  logic [2:0]      op;
  logic [W-1:0]    r_s, r_ss, r_rem;
  logic            r_c, r_v, r_e;
  logic [W:0]      div_shift, div_diff;
  logic            div_ge;

  // Restoring-division step: bring in the next dividend bit and trial-subtract.
  always_comb begin
    div_shift = {rem_q, a_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
  end

  // In IDLE the result comes straight from the ports; in CALC from the iteration registers.
  always_comb begin
    op    = (state_q == IDLE) ? Sel : sel_q;
    r_s   = '0;
    r_rem = '0;
    r_c   = 1'b0;
    r_v   = 1'b0;
    r_e   = 1'b0;
    case (op)
      OP_ADD: begin
        {r_c, r_s} = {1'b0, A} + {1'b0, B};
        r_v = (A[W-1] == B[W-1]) && (r_s[W-1] != A[W-1]);
      end
      OP_SUB: begin
        {r_c, r_s} = {1'b0, A} - {1'b0, B};
        r_v = (A[W-1] != B[W-1]) && (r_s[W-1] != A[W-1]);
      end
      OP_MUL: begin
        r_s = prod_q[W-1:0];
        r_c = |prod_q[2*W-1:W];
      end
      OP_DIV: begin
        r_s   = quo_q;
        r_rem = rem_q;
        r_e   = (b_q == '0);
      end
      OP_AND:  r_s = A & B;
      OP_OR:   r_s = A | B;
      OP_XOR:  r_s = A ^ B;
      OP_NOT:  r_s = ~A;
      default: r_s = '0;
    endcase
    r_ss = r_s;
    if (SAT && r_c) begin
      if (op == OP_SUB) r_ss = '0;
      else              r_ss = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ula_start) begin
          a_d   = A;
          b_d   = B;
          sel_d = Sel;
          if (Sel == OP_MUL || Sel == OP_DIV) begin
            state_d = CALC;
            cnt_d   = '0;
            prod_d  = '0;
            mcand_d = {{W{1'b0}}, A};
            rem_d   = '0;
            quo_d   = '0;
          end else begin
            load    = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        // W iteration steps, then one extra cycle to register the finished result.
        if (cnt_q == CNT_LAST) begin
          load    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (sel_q == OP_MUL) begin
            prod_d  = prod_q + (b_q[0] ? mcand_q : '0);
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
          end else begin
            rem_d = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
            quo_d = {quo_q[W-2:0], div_ge};
            a_d   = a_q << 1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    s_d     = load ? r_s   : s_q;
    ss_d    = load ? r_ss  : ss_q;
    rdr_d   = load ? r_rem : rdr_q;
    flags_d = load ? {r_e, r_v, r_s[W-1], r_c, (r_s == '0)} : flags_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      s_q     <= '0;
      ss_q    <= '0;
      rdr_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      s_q     <= s_d;
      ss_q    <= ss_d;
      rdr_q   <= rdr_d;
      flags_q <= flags_d;
    end
  end

  assign S           = s_q;
  assign SS          = ss_q;
  assign res_div_res = rdr_q;
  assign flags       = flags_q;
  assign busy        = (state_q == CALC);
  assign ula_pronto  = (state_q == DONE);

endmodule

// File: tb/tb_ula_nbits_seq.sv
// Testbench for ula_nbits_seq: an arithmetic reference model checked every cycle,
// plus directed cases with hand-computed results, then randomized traffic.
module tb_ula_nbits_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [2:0]   sel_in = '0;

  logic [W-1:0] s1, ss1, rem1, s0, ss0, rem0;
  logic [4:0]   fl1, fl0;
  logic         busy1, busy0, pr1, pr0;

  int checks   = 0;
  int failures = 0;

  ula_nbits_seq #(.W(W), .SAT(1'b1)) u_dut_sat (
    .Clk(clk), .Reset(reset), .ula_start(start), .A(a_in), .B(b_in), .Sel(sel_in),
    .S(s1), .SS(ss1), .res_div_res(rem1), .flags(fl1), .busy(busy1), .ula_pronto(pr1)
  );

  ula_nbits_seq #(.W(W), .SAT(1'b0)) u_dut_nosat (
    .Clk(clk), .Reset(reset), .ula_start(start), .A(a_in), .B(b_in), .Sel(sel_in),
    .S(s0), .SS(ss0), .res_div_res(rem0), .flags(fl0), .busy(busy0), .ula_pronto(pr0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Expected result of one operation, straight from the arithmetic definitions.
  function automatic void model_op(input longint a, input longint b, input int sel,
                                   output longint s, output longint ss, output longint rem,
                                   output logic [4:0] fl);
    longint mask, half, full, sa, sb, sr;
    bit c, v, e;
    mask = (longint'(1) << W) - 1;
    half = longint'(1) << (W - 1);
    sa = (a >= half) ? a - (mask + 1) : a;
    sb = (b >= half) ? b - (mask + 1) : b;
    c = 1'b0; v = 1'b0; e = 1'b0; rem = 0; s = 0;
    case (sel)
      0: begin full = a + b; s = full & mask; c = (full > mask); sr = sa + sb; v = (sr >= half) || (sr < -half); end
      1: begin full = a - b; s = full & mask; c = (a < b);       sr = sa - sb; v = (sr >= half) || (sr < -half); end
      2: begin full = a * b; s = full & mask; c = (full > mask); end
      3: begin
        if (b == 0) begin s = mask; rem = a; e = 1'b1; end
        else begin s = a / b; rem = a % b; end
      end
      4: s = a & b;
      5: s = a | b;
      6: s = a ^ b;
      default: s = mask - a;
    endcase
    ss = s;
    if (c && (sel == 0 || sel == 2)) ss = mask;
    if (c && sel == 1) ss = 0;
    fl = {e, v, s[W-1], c, (s == 0)};
  endfunction

  // Reference model state: what the outputs must show after each rising edge.
  logic [W-1:0] m_s = '0, m_ss = '0, m_rem = '0;
  logic [4:0]   m_fl = '0;
  bit           m_busy = 1'b0, m_pronto = 1'b0, model_valid = 1'b0;

  initial begin
    longint p_s, p_ss, p_rem;
    logic [4:0] p_fl;
    int pend;
    bit in_done;
    pend = 0; in_done = 1'b0;
    p_s = 0; p_ss = 0; p_rem = 0; p_fl = '0;
    forever begin
      @(posedge clk);
      m_pronto = 1'b0;
      if (reset) begin
        m_s = '0; m_ss = '0; m_rem = '0; m_fl = '0;
        pend = 0; in_done = 1'b0;
        model_valid = 1'b1;
      end else if (in_done) begin
        in_done = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_s = W'(p_s); m_ss = W'(p_ss); m_rem = W'(p_rem); m_fl = p_fl;
          m_pronto = 1'b1; in_done = 1'b1;
        end
      end else if (start) begin
        model_op(longint'(a_in), longint'(b_in), int'(sel_in), p_s, p_ss, p_rem, p_fl);
        if (sel_in == 3'd2 || sel_in == 3'd3) begin
          pend = W + 1;
        end else begin
          m_s = W'(p_s); m_ss = W'(p_ss); m_rem = W'(p_rem); m_fl = p_fl;
          m_pronto = 1'b1; in_done = 1'b1;
        end
      end
      m_busy = (pend > 0);
    end
  end

  // Every cycle, both instances are compared with the model; the unsaturated one has SS == S.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        checkOutput("S",          32'(s1),    32'(m_s));
        checkOutput("SS",         32'(ss1),   32'(m_ss));
        checkOutput("rem",        32'(rem1),  32'(m_rem));
        checkOutput("flags",      32'(fl1),   32'(m_fl));
        checkOutput("busy",       32'(busy1), 32'(m_busy));
        checkOutput("pronto",     32'(pr1),   32'(m_pronto));
        checkOutput("S_nosat",    32'(s0),    32'(m_s));
        checkOutput("SS_nosat",   32'(ss0),   32'(m_s));
        checkOutput("rem_nosat",  32'(rem0),  32'(m_rem));
        checkOutput("busy_nosat", 32'(busy0), 32'(m_busy));
        checkOutput("pr_nosat",   32'(pr0),   32'(m_pronto));
      end
    end
  end

  // Issue one operation, scramble the inputs afterwards, and count edges until ula_pronto.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                               output int lat, output int busy_cnt);
    @(negedge clk);
    a_in = a; b_in = b; sel_in = sel; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = W'($urandom()); b_in = W'($urandom()); sel_in = 3'($urandom());
    lat = 0; busy_cnt = 0;
    while (pr1 !== 1'b1 && lat < 40) begin
      if (busy1 === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) checkOutput("pronto_timeout", 32'(pr1), 32'd1);
  endtask

  task automatic runDirected(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] sel, input logic [W-1:0] exp_s, input logic [W-1:0] exp_ss,
                             input logic [W-1:0] exp_rem, input logic [4:0] exp_fl, input int exp_lat);
    int lat, busy_cnt;
    applyStimulus(a, b, sel, lat, busy_cnt);
    checkOutput({name, " latency"},  32'(lat),      32'(exp_lat));
    checkOutput({name, " busy_cyc"}, 32'(busy_cnt), 32'(exp_lat));
    checkOutput({name, " S"},        32'(s1),       32'(exp_s));
    checkOutput({name, " SS"},       32'(ss1),      32'(exp_ss));
    checkOutput({name, " rem"},      32'(rem1),     32'(exp_rem));
    checkOutput({name, " flags"},    32'(fl1),      32'(exp_fl));
    checkOutput({name, " SS_nosat"}, 32'(ss0),      32'(exp_s));
    @(negedge clk);
    checkOutput({name, " pulse_end"}, 32'(pr1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset S",      32'(s1),    32'd0);
    checkOutput("reset SS",     32'(ss1),   32'd0);
    checkOutput("reset rem",    32'(rem1),  32'd0);
    checkOutput("reset flags",  32'(fl1),   32'd0);
    checkOutput("reset busy",   32'(busy1), 32'd0);
    checkOutput("reset pronto", 32'(pr1),   32'd0);
    reset = 1'b0;

    runDirected("ADD 200+100", 8'd200, 8'd100, 3'd0, 8'h2C, 8'hFF, 8'h00, 5'b00010, 0);
    runDirected("SUB 5-10",    8'd5,   8'd10,  3'd1, 8'hFB, 8'h00, 8'h00, 5'b00110, 0);
    runDirected("MUL 20*15",   8'd20,  8'd15,  3'd2, 8'h2C, 8'hFF, 8'h00, 5'b00010, W + 1);
    runDirected("MUL 12*10",   8'd12,  8'd10,  3'd2, 8'h78, 8'h78, 8'h00, 5'b00000, W + 1);

    // A second start during CALC must not disturb the running multiply.
    @(negedge clk);
    a_in = 8'd20; b_in = 8'd15; sel_in = 3'd2; start = 1'b1;
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    while (pr1 !== 1'b1 && lat < 40) begin
      if (lat == 2) begin a_in = 8'd99; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checkOutput("ignored start latency", 32'(lat), 32'(W + 1));
    checkOutput("ignored start S",       32'(s1),  32'h2C);
    @(negedge clk);

    // Reset in the fourth cycle of a multiply aborts it with no pronto pulse.
    @(negedge clk);
    a_in = 8'd12; b_in = 8'd10; sel_in = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort S",      32'(s1),    32'd0);
    checkOutput("abort SS",     32'(ss1),   32'd0);
    checkOutput("abort flags",  32'(fl1),   32'd0);
    checkOutput("abort busy",   32'(busy1), 32'd0);
    checkOutput("abort pronto", 32'(pr1),   32'd0);
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      checkOutput("abort no pronto", 32'(pr1), 32'd0);
    end

    runDirected("DIV 200/7",   8'd200, 8'd7,   3'd3, 8'h1C, 8'h1C, 8'h04, 5'b00000, W + 1);
    runDirected("DIV 55/0",    8'd55,  8'd0,   3'd3, 8'hFF, 8'hFF, 8'h37, 5'b10100, W + 1);
    runDirected("AND F0,0F",   8'hF0,  8'h0F,  3'd4, 8'h00, 8'h00, 8'h00, 5'b00001, 0);
    runDirected("NOT 5A",      8'h5A,  8'h00,  3'd7, 8'hA5, 8'hA5, 8'h00, 5'b00100, 0);
    runDirected("ADD 100+100", 8'd100, 8'd100, 3'd0, 8'hC8, 8'hC8, 8'h00, 5'b01100, 0);

    // Random traffic: starts at any time, occasional divide-by-zero and reset.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 80) == 0);
      start  = ($urandom_range(0, 2) != 0);
      a_in   = W'($urandom());
      b_in   = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom());
      sel_in = 3'($urandom());
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
